frame_bus_sched: RTL and testbench

Schedules SDRAM burst traffic for the capture-to-display frame buffer on the ctrl_clk domain. Watches the write-FIFO read-side fill level (camera pixels awaiting storage) and the read-FIFO write-side fill level (display prefetch). Decides which direction gets the memory controller next, issues one fixed-length burst request at a time with a frame-relative word address, and tracks frame address wrap for both directions.

---
 rtl/frame_bus_sched_if.sv | 25 ++
 rtl/frame_bus_sched.sv | 198 +++++++++++++++++++
 tb/tb_frame_bus_sched.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_bus_sched_if.sv
// Memory-controller burst request bus between frame_bus_sched (master) and the SDRAM
// controller (slave): request, direction and start address out; accept and completion back.
interface frame_bus_sched_if;
  logic        mem_req;
  logic        mem_we;
  logic [22:0] mem_addr;
  logic        mem_ack;
  logic        mem_done;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    input  mem_ack,
    input  mem_done
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    output mem_ack,
    output mem_done
  );
endinterface

// File: rtl/frame_bus_sched.sv
// Frame-buffer SDRAM burst scheduler: arbitrates camera writes against display reads.
// Define FRAME_BUS_WATCHDOG_EN to build the REQ/BURST watchdog and the sticky err flag.
module frame_bus_sched #(
  parameter int unsigned BURST_LEN    = 16,
  parameter int unsigned FRAME_WORDS  = 76800,
  parameter int unsigned WR_BASE      = 0,
  parameter int unsigned RD_BASE      = 0,
  parameter int unsigned FIFO_DEPTH   = 512,
  parameter int unsigned RD_LOW_WATER = 128,
  parameter int unsigned TIMEOUT      = 1023
) (
  input  logic                     ctrl_clk,
  input  logic                     reset_n,
  input  logic [8:0]               write_fifo_rdusedw,
  input  logic [8:0]               read_fifo_wrusedw,
  input  logic                     read_init,
  frame_bus_sched_if.master        mem,
  output logic                     wr_frame_done,
  output logic                     rd_frame_done,
  output logic                     busy,
  output logic                     err
);

  typedef enum logic [1:0] {StIdle, StReq, StBurst} state_e;

  localparam logic [22:0] WrBase   = 23'(WR_BASE);
  localparam logic [22:0] RdBase   = 23'(RD_BASE);
  localparam logic [23:0] WrEnd    = 24'(WR_BASE + FRAME_WORDS);
  localparam logic [23:0] RdEnd    = 24'(RD_BASE + FRAME_WORDS);
  localparam logic [23:0] BurstInc = 24'(BURST_LEN);
  localparam int unsigned RdRoom   = FIFO_DEPTH - 1 - BURST_LEN;

  if (BURST_LEN > 256 || (FRAME_WORDS % BURST_LEN) != 0 || TIMEOUT == 0) begin : g_param_check
    $error("frame_bus_sched: invalid parameter set");
  end

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [22:0] addr_q, addr_d;
  logic [22:0] wr_addr_q, wr_addr_d;
  logic [22:0] rd_addr_q, rd_addr_d;
  logic        last_wr_q, last_wr_d;
  logic        rd_arm_q, rd_arm_d;
  logic        wr_fd_q, wr_fd_d;
  logic        rd_fd_q, rd_fd_d;
  logic [1:0]  sync_q;
  logic        init_prev_q;

  logic        init_s, init_rise;
  logic        wr_ok, rd_ok, rd_urgent, grant, grant_wr;
  logic [23:0] wr_next, rd_next;
  logic        wd_timeout;

  assign init_s    = sync_q[1];
  assign init_rise = init_s & ~init_prev_q;

  assign wr_ok     = 32'(write_fifo_rdusedw) >= BURST_LEN;
  assign rd_ok     = rd_arm_q && (32'(read_fifo_wrusedw) <= RdRoom);
  assign rd_urgent = rd_ok && (32'(read_fifo_wrusedw) < RD_LOW_WATER);
  assign grant     = wr_ok | rd_ok;
  // Urgent reads pre-empt; a tie alternates away from the previous winner.
  assign grant_wr  = rd_urgent ? 1'b0 : ((wr_ok && rd_ok) ? ~last_wr_q : wr_ok);

  assign wr_next = {1'b0, wr_addr_q} + BurstInc;
  assign rd_next = {1'b0, rd_addr_q} + BurstInc;

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    last_wr_d = last_wr_q;
    rd_arm_d  = rd_arm_q;
    wr_fd_d   = 1'b0;
    rd_fd_d   = 1'b0;

    if (init_rise) begin
      rd_arm_d = 1'b1;
    end else if (!init_s) begin
      rd_arm_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (grant) begin
          state_d   = StReq;
          we_d      = grant_wr;
          addr_d    = grant_wr ? wr_addr_q : rd_addr_q;
          last_wr_d = grant_wr;
        end
      end
      StReq: begin
        if (mem.mem_ack) begin
          state_d = StBurst;
        end else if (wd_timeout) begin
          state_d = StIdle;
        end
      end
      StBurst: begin
        if (mem.mem_done) begin
          state_d = StIdle;
          if (we_q) begin
            if (wr_next == WrEnd) begin
              wr_addr_d = WrBase;
              wr_fd_d   = 1'b1;
            end else begin
              wr_addr_d = wr_next[22:0];
            end
          end else begin
            if (rd_next == RdEnd) begin
              rd_addr_d = RdBase;
              rd_fd_d   = 1'b1;
            end else begin
              rd_addr_d = rd_next[22:0];
            end
          end
        end else if (wd_timeout) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A fresh display enable restarts the read frame regardless of burst activity.
    if (init_rise) begin
      rd_addr_d = RdBase;
    end
  end

  always_ff @(posedge ctrl_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wr_addr_q   <= WrBase;
      rd_addr_q   <= RdBase;
      last_wr_q   <= 1'b0;
      rd_arm_q    <= 1'b0;
      wr_fd_q     <= 1'b0;
      rd_fd_q     <= 1'b0;
      sync_q      <= '0;
      init_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      last_wr_q   <= last_wr_d;
      rd_arm_q    <= rd_arm_d;
      wr_fd_q     <= wr_fd_d;
      rd_fd_q     <= rd_fd_d;
      sync_q      <= {sync_q[0], read_init};
      init_prev_q <= init_s;
    end
  end

`ifdef FRAME_BUS_WATCHDOG_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] wd_cnt_q;
  logic            err_q;

  // Fires on the TIMEOUT-th cycle spent in the current REQ or BURST visit.
  assign wd_timeout = (state_q != StIdle) && (wd_cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge ctrl_clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_d != state_q) begin
        wd_cnt_q <= '0;
      end else if (state_q != StIdle) begin
        wd_cnt_q <= wd_cnt_q + 1'b1;
      end
      if (wd_timeout && ((state_q == StReq && !mem.mem_ack) ||
                         (state_q == StBurst && !mem.mem_done))) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign wd_timeout = 1'b0;
  assign err        = 1'b0;
`endif

  assign mem.mem_req   = (state_q == StReq);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign busy          = (state_q != StIdle);
  assign wr_frame_done = wr_fd_q;
  assign rd_frame_done = rd_fd_q;

endmodule

// File: tb/tb_frame_bus_sched.sv
// Self-checking bench for frame_bus_sched: random FIFO levels and controller timing against
// a frame-offset reference model, plus directed boundary, disarm and mid-burst reset steps.
module tb_frame_bus_sched;
  localparam int BL = 16;
  localparam int FW = 64;
  localparam int WB = 256;
  localparam int RB = 4096;
  localparam int TabN = 11;

  logic       clk;
  logic       rst_n;
  logic [8:0] wl;
  logic [8:0] rl;
  logic       read_init;
  logic       wfd;
  logic       rfd;
  logic       busy;
  logic       err;

  frame_bus_sched_if mem ();

  frame_bus_sched #(
    .BURST_LEN  (BL),
    .FRAME_WORDS(FW),
    .WR_BASE    (WB),
    .RD_BASE    (RB)
  ) dut (
    .ctrl_clk          (clk),
    .reset_n           (rst_n),
    .write_fifo_rdusedw(wl),
    .read_fifo_wrusedw (rl),
    .read_init         (read_init),
    .mem               (mem),
    .wr_frame_done     (wfd),
    .rd_frame_done     (rfd),
    .busy              (busy),
    .err               (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frame-relative offsets per direction plus arbitration memory.
  int m_wr;
  int m_rd;
  bit m_last_wr;
  bit m_arm;

  int tab_w[TabN] = '{15, 16, 15, 200, 200, 15, 200, 300, 300, 300, 0};
  int tab_r[TabN] = '{496, 496, 495, 128, 128, 128, 127, 300, 300, 300, 50};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wr = 0;
    m_rd = 0;
    m_last_wr = 1'b0;
    m_arm = 1'b0;
  endtask

  task automatic predict(output bit have, output bit we);
    bit wok, rok, urg;
    wok = int'(wl) >= BL;
    rok = m_arm && (int'(rl) + BL < 512);
    urg = rok && (int'(rl) < 128);
    have = wok || rok;
    if (urg) we = 1'b0;
    else if (wok && rok) we = !m_last_wr;
    else we = wok;
  endtask

  task automatic rand_lv(output logic [8:0] a, output logic [8:0] b);
    a = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 15)) : 9'($urandom_range(16, 511));
    case ($urandom_range(0, 3))
      0:       b = 9'($urandom_range(0, 127));
      1:       b = 9'($urandom_range(496, 511));
      default: b = 9'($urandom_range(128, 495));
    endcase
  endtask

  // Runs one scheduling opportunity; nwl/nrl become the FIFO levels for the next one.
  task automatic step(input logic [8:0] nwl, input logic [8:0] nrl, input bit drop);
    bit          have, we, saw, stable, ew, er;
    int          n, d, e;
    logic [22:0] exp_addr;
    predict(have, we);
    if (!have) begin
      saw = 1'b0;
      repeat (6) begin
        @(negedge clk);
        saw |= mem.mem_req;
      end
      chk("idle_no_req", 32'(saw), 32'(0));
      wl = nwl;
      rl = nrl;
      return;
    end
    exp_addr  = 23'(we ? WB + m_wr : RB + m_rd);
    m_last_wr = we;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mem.mem_req !== 1'b1 && n < 20);
    chk("req_latency", 32'(n), 32'(1));
    chk("req_we", 32'(mem.mem_we), 32'(we));
    chk("req_addr", 32'(mem.mem_addr), 32'(exp_addr));
    chk("frame_done_single", 32'({wfd, rfd}), 32'(0));
    if (mem.mem_req !== 1'b1) return;
    d = $urandom_range(0, 3);
    stable = 1'b1;
    for (int i = 0; i < d; i++) begin
      if (i == 0) mem.mem_done = 1'b1;
      @(negedge clk);
      mem.mem_done = 1'b0;
      stable &= (mem.mem_req === 1'b1) && (mem.mem_addr === exp_addr) && (mem.mem_we === we);
    end
    chk("req_hold", 32'(stable), 32'(1));
    mem.mem_ack = 1'b1;
    @(negedge clk);
    mem.mem_ack = 1'b0;
    chk("req_drop", 32'({mem.mem_req, busy}), 32'(2'b01));
    if (drop) read_init = 1'b0;
    e = drop ? 6 : $urandom_range(0, 4);
    for (int i = 0; i < e; i++) begin
      if (i == 0) mem.mem_ack = 1'b1;
      @(negedge clk);
      mem.mem_ack = 1'b0;
    end
    wl = nwl;
    rl = nrl;
    mem.mem_done = 1'b1;
    @(negedge clk);
    mem.mem_done = 1'b0;
    ew = 1'b0;
    er = 1'b0;
    if (we) begin
      m_wr += BL;
      if (m_wr == FW) begin m_wr = 0; ew = 1'b1; end
    end else begin
      m_rd += BL;
      if (m_rd == FW) begin m_rd = 0; er = 1'b1; end
    end
    if (drop) m_arm = 1'b0;
    chk("frame_done", 32'({wfd, rfd}), 32'({ew, er}));
    chk("back_idle", 32'({busy, mem.mem_req}), 32'(0));
  endtask

  // Only called with nothing eligible, so the synchroniser settles while idle.
  task automatic set_init(input bit v);
    read_init = v;
    repeat (6) @(negedge clk);
    if (v) begin
      m_arm = 1'b1;
      m_rd  = 0;
    end else begin
      m_arm = 1'b0;
    end
    chk("init_idle", 32'(busy), 32'(0));
  endtask

  task automatic rand_steps(input int cnt);
    logic [8:0] a, b;
    for (int i = 0; i < cnt; i++) begin
      rand_lv(a, b);
      step(a, b, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not reach its summary");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    rst_n        = 1'b0;
    wl           = '0;
    rl           = '0;
    read_init    = 1'b0;
    mem.mem_ack  = 1'b0;
    mem.mem_done = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_req_busy", 32'({mem.mem_req, mem.mem_we, busy}), 32'(0));
    chk("rst_addr", 32'(mem.mem_addr), 32'(0));
    chk("rst_flags", 32'({wfd, rfd, err}), 32'(0));
    rst_n = 1'b1;

    // Writes only: reads stay disarmed.
    rand_steps(14);
    step(9'd0, 9'd511, 1'b0);
    set_init(1'b1);

    rand_steps(40);
    for (int i = 0; i < TabN; i++) step(9'(tab_w[i]), 9'(tab_r[i]), 1'b0);
    // Urgent read with the display enable dropped mid-burst.
    step(9'd0, 9'd511, 1'b1);

    rand_steps(15);
    step(9'd0, 9'd511, 1'b0);
    set_init(1'b1);
    rand_steps(15);
    step(9'd300, 9'd511, 1'b0);

    // Reset in the middle of a write burst.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mem.mem_req !== 1'b1 && n < 20);
    chk("rst_mid_req", 32'(mem.mem_req), 32'(1));
    mem.mem_ack = 1'b1;
    @(negedge clk);
    mem.mem_ack = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 32'(busy), 32'(1));
    rst_n     = 1'b0;
    read_init = 1'b0;
    wl        = 9'd0;
    rl        = 9'd511;
    #1;
    chk("rst_mid_outs", 32'({busy, mem.mem_req, mem.mem_we, wfd, rfd, err}), 32'(0));
    chk("rst_mid_addr", 32'(mem.mem_addr), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    rand_steps(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
